// File: rtl/target_codeblock_lp_pkg.sv
// Package for the target-side (optimised) secret-doubling code block.
// Holds the program-counter encodings, the default widths, and the mod-3
// helper that replaces the loop-invariant output arithmetic.
package target_cb_pkg;

  localparam int DEF_ITERATIONS = 3;
  localparam int DEF_SECRET_W   = 2;
  localparam int DEF_X_W        = 4;

  // Width of the argument to mod3. Callers zero-extend their X_W-bit
  // accumulator to this width, so X_W must not exceed it.
  localparam int MOD3_W = 32;

  typedef enum logic [3:0] {
    ENTRY = 4'd0,
    INIT  = 4'd1,
    PEEL  = 4'd2,
    EMIT  = 4'd3,
    TEST  = 4'd4,
    BODY  = 4'd5,
    HALT  = 4'd6
  } pc_t;

  // Unsigned remainder modulo 3; the result is always 0..2.
  function automatic logic [1:0] mod3(input logic [MOD3_W-1:0] v);
    logic [MOD3_W-1:0] r;
    r = v % MOD3_W'(3);
    return r[1:0];
  endfunction

endpackage

// File: rtl/target_codeblock_lp_if.sv
// Handshake bundle between the environment (master) and the code block
// (slave).
//   stutter_in  master->slave  hold the program this cycle
//   secret_in   master->slave  secret operand, sampled only in PEEL
//   public_out  slave->master  last emitted public value (registered)
//   stutter     slave->master  registered copy of stutter_in
//   halted      slave->master  high while the program sits in HALT
interface target_codeblock_lp_if
  import target_cb_pkg::*;
#(
  parameter int SECRET_W = DEF_SECRET_W
);
  logic                stutter_in;
  logic [SECRET_W-1:0] secret_in;
  logic [1:0]          public_out;
  logic                stutter;
  logic                halted;

  modport master (
    output stutter_in,
    output secret_in,
    input  public_out,
    input  stutter,
    input  halted
  );

  modport slave (
    input  stutter_in,
    input  secret_in,
    output public_out,
    output stutter,
    output halted
  );
endinterface

// File: rtl/target_codeblock_lp.sv
// Target-side model of the secret-doubling code block. The first loop
// iteration is peeled (PEEL loads the secret and sets k=1 directly), and the
// per-emission output arithmetic is reduced to x mod 3. The k-th emission is
// (secret * 2^(k-1) mod 2^X_W) mod 3.
// Ports:
//   clk    system clock, all state changes on posedge
//   rst_n  asynchronous active-low reset
//   bus    slave side of target_codeblock_lp_if (stutter_in, secret_in in;
//          public_out, stutter, halted out)
module target_codeblock_lp
  import target_cb_pkg::*;
#(
  parameter int ITERATIONS = DEF_ITERATIONS,
  parameter int SECRET_W   = DEF_SECRET_W,
  parameter int X_W        = DEF_X_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  target_codeblock_lp_if.slave  bus
);

  // k counts completed iterations, so it must hold ITERATIONS itself.
  localparam int K_W = $clog2(ITERATIONS + 1);

  pc_t                 pc_reg;
  logic [X_W-1:0]      x_reg;
  logic [K_W-1:0]      k_reg;
  logic [1:0]          public_out_reg;
  logic                stutter_reg;
  logic [SECRET_W-1:0] secret_s;

  assign secret_s = bus.secret_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= ENTRY;
      x_reg          <= '0;
      k_reg          <= '0;
      public_out_reg <= '0;
      stutter_reg    <= 1'b0;
    end else begin
      stutter_reg <= bus.stutter_in;
      // A stuttered cycle freezes the whole program, HALT included.
      if (!bus.stutter_in) begin
        case (pc_reg)
          ENTRY: pc_reg <= INIT;
          INIT: begin
            x_reg  <= '0;
            k_reg  <= '0;
            pc_reg <= PEEL;
          end
          PEEL: begin
            x_reg  <= X_W'(secret_s);
            k_reg  <= K_W'(1);
            pc_reg <= EMIT;
          end
          EMIT: begin
            public_out_reg <= mod3(MOD3_W'(x_reg));
            pc_reg         <= TEST;
          end
          TEST: begin
            if (k_reg < K_W'(ITERATIONS)) pc_reg <= BODY;
            else                          pc_reg <= HALT;
          end
          BODY: begin
            x_reg  <= x_reg + x_reg;
            k_reg  <= k_reg + K_W'(1);
            pc_reg <= EMIT;
          end
          HALT:    pc_reg <= HALT;
          // Unused encodings park the program without touching data.
          default: pc_reg <= HALT;
        endcase
      end
    end
  end

  assign bus.public_out = public_out_reg;
  assign bus.stutter    = stutter_reg;
  assign bus.halted     = (pc_reg == HALT);

endmodule

// File: tb/tb_target_codeblock_lp.sv
// Directed bench for target_codeblock_lp: emission sequences for several
// secrets, stuttering, secret changes outside PEEL, mid-run reset, and a
// single-iteration build.
module tb_target_codeblock_lp;
  import target_cb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  target_codeblock_lp_if #(.SECRET_W(2)) bus0 ();
  target_codeblock_lp_if #(.SECRET_W(2)) bus1 ();

  target_codeblock_lp #(.ITERATIONS(3), .SECRET_W(2), .X_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  target_codeblock_lp #(.ITERATIONS(1), .SECRET_W(2), .X_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two falling edges and release on a falling edge, so the
  // next rising edge is posedge 1 of the run.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.stutter_in = 1'b1;
    bus0.secret_in  = 2'd3;
    tick();
    tick();
    checks++;
    if (bus0.public_out !== 2'd0) $display("FAIL reset_public_out got %0d want 0", bus0.public_out);
    else passed++;
    checks++;
    if (bus0.stutter !== 1'b0) $display("FAIL reset_stutter got %0b want 0", bus0.stutter);
    else passed++;
    checks++;
    if (bus0.halted !== 1'b0) $display("FAIL reset_halted got %0b want 0", bus0.halted);
    else passed++;
    checks++;
    if (dut.x_reg !== 4'd0 || dut.k_reg !== 2'd0) $display("FAIL reset_x_k got x=%0d k=%0d want 0 0", dut.x_reg, dut.k_reg);
    else passed++;
    bus0.stutter_in = 1'b0;
  endtask

  task automatic test_secret1();
    logic [1:0] exp_out;
    logic       exp_halt;
    bus0.stutter_in = 1'b0;
    bus0.secret_in  = 2'd1;
    do_reset();
    for (int p = 1; p <= 14; p++) begin
      tick();
      exp_out  = (p < 4) ? 2'd0 : (p < 7) ? 2'd1 : (p < 10) ? 2'd2 : 2'd1;
      exp_halt = (p >= 11);
      checks++;
      if (bus0.public_out !== exp_out) $display("FAIL secret1_out p=%0d got %0d want %0d", p, bus0.public_out, exp_out);
      else passed++;
      checks++;
      if (bus0.halted !== exp_halt) $display("FAIL secret1_halted p=%0d got %0b want %0b", p, bus0.halted, exp_halt);
      else passed++;
    end
    $display("secret=1 sequence 1,2,1 checked through posedge 14");
  endtask

  task automatic test_emissions();
    logic [1:0] secrets [3];
    logic [1:0] exp_seq [3][3];
    logic [1:0] exp_out;
    secrets = '{2'd2, 2'd3, 2'd0};
    // x = s, 2s, 4s (mod 16), each reduced mod 3
    exp_seq = '{'{2'd2, 2'd1, 2'd2}, '{2'd0, 2'd0, 2'd0}, '{2'd0, 2'd0, 2'd0}};
    for (int t = 0; t < 3; t++) begin
      bus0.stutter_in = 1'b0;
      bus0.secret_in  = secrets[t];
      do_reset();
      for (int p = 1; p <= 12; p++) begin
        tick();
        exp_out = (p < 4) ? 2'd0 : (p < 7) ? exp_seq[t][0] : (p < 10) ? exp_seq[t][1] : exp_seq[t][2];
        checks++;
        if (bus0.public_out !== exp_out) $display("FAIL emit_s%0d_out p=%0d got %0d want %0d", secrets[t], p, bus0.public_out, exp_out);
        else passed++;
      end
      checks++;
      if (bus0.halted !== 1'b1) $display("FAIL emit_s%0d_halted got %0b want 1", secrets[t], bus0.halted);
      else passed++;
      $display("secret=%0d sequence %0d,%0d,%0d checked", secrets[t], exp_seq[t][0], exp_seq[t][1], exp_seq[t][2]);
    end
  endtask

  task automatic test_stutter();
    logic [1:0] exp_out;
    logic       exp_halt;
    logic       exp_stut;
    bus0.stutter_in = 1'b0;
    bus0.secret_in  = 2'd1;
    do_reset();
    for (int p = 1; p <= 16; p++) begin
      tick();
      exp_out  = (p < 7) ? 2'd0 : (p < 10) ? 2'd1 : (p < 13) ? 2'd2 : 2'd1;
      exp_halt = (p >= 14);
      exp_stut = (p >= 3 && p <= 5);
      checks++;
      if (bus0.public_out !== exp_out) $display("FAIL stutter_out p=%0d got %0d want %0d", p, bus0.public_out, exp_out);
      else passed++;
      checks++;
      if (bus0.halted !== exp_halt) $display("FAIL stutter_halted p=%0d got %0b want %0b", p, bus0.halted, exp_halt);
      else passed++;
      checks++;
      if (bus0.stutter !== exp_stut) $display("FAIL stutter_echo p=%0d got %0b want %0b", p, bus0.stutter, exp_stut);
      else passed++;
      if (p >= 2 && p <= 5) begin
        checks++;
        if (dut.pc_reg !== PEEL || dut.x_reg !== 4'd0 || dut.k_reg !== 2'd0)
          $display("FAIL stutter_frozen p=%0d got pc=%0d x=%0d k=%0d want 2 0 0", p, dut.pc_reg, dut.x_reg, dut.k_reg);
        else passed++;
      end
      if (p == 2) bus0.stutter_in = 1'b1;
      if (p == 5) bus0.stutter_in = 1'b0;
    end
    $display("stutter on posedges 3..5: sequence shifted by 3 checked");
  endtask

  task automatic test_secret_toggle();
    logic [1:0] exp_out;
    bus0.stutter_in = 1'b0;
    bus0.secret_in  = 2'd1;
    do_reset();
    for (int p = 1; p <= 12; p++) begin
      tick();
      exp_out = (p < 4) ? 2'd0 : (p < 7) ? 2'd1 : (p < 10) ? 2'd2 : 2'd1;
      checks++;
      if (bus0.public_out !== exp_out) $display("FAIL toggle_out p=%0d got %0d want %0d", p, bus0.public_out, exp_out);
      else passed++;
      if (p >= 3) bus0.secret_in = (p % 2 == 1) ? 2'd3 : 2'd0;
    end
    $display("secret toggled after PEEL: sequence 1,2,1 checked");
  endtask

  task automatic test_midrun_reset();
    logic [1:0] exp_out;
    bus0.stutter_in = 1'b0;
    bus0.secret_in  = 2'd1;
    do_reset();
    for (int p = 1; p <= 5; p++) tick();
    checks++;
    if (dut.pc_reg !== BODY || bus0.public_out !== 2'd1) $display("FAIL midrun_pre got pc=%0d out=%0d want 5 1", dut.pc_reg, bus0.public_out);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.public_out !== 2'd0 || dut.x_reg !== 4'd0 || dut.k_reg !== 2'd0 || bus0.halted !== 1'b0)
      $display("FAIL midrun_async got out=%0d x=%0d k=%0d halted=%0b want 0 0 0 0", bus0.public_out, dut.x_reg, dut.k_reg, bus0.halted);
    else passed++;
    checks++;
    if (dut.pc_reg !== ENTRY) $display("FAIL midrun_pc got %0d want 0", dut.pc_reg);
    else passed++;
    #1 rst_n = 1'b1;
    for (int p = 1; p <= 11; p++) begin
      tick();
      exp_out = (p < 4) ? 2'd0 : (p < 7) ? 2'd1 : (p < 10) ? 2'd2 : 2'd1;
      checks++;
      if (bus0.public_out !== exp_out) $display("FAIL midrun_replay_out p=%0d got %0d want %0d", p, bus0.public_out, exp_out);
      else passed++;
    end
    checks++;
    if (bus0.halted !== 1'b1) $display("FAIL midrun_replay_halted got %0b want 1", bus0.halted);
    else passed++;
    $display("mid-run async reset and replay checked");
  endtask

  task automatic test_iter1();
    logic [1:0] exp_out;
    logic       exp_halt;
    bus1.stutter_in = 1'b0;
    bus1.secret_in  = 2'd2;
    do_reset();
    for (int p = 1; p <= 8; p++) begin
      tick();
      exp_out  = (p < 4) ? 2'd0 : 2'd2;
      exp_halt = (p >= 5);
      checks++;
      if (bus1.public_out !== exp_out) $display("FAIL iter1_out p=%0d got %0d want %0d", p, bus1.public_out, exp_out);
      else passed++;
      checks++;
      if (bus1.halted !== exp_halt) $display("FAIL iter1_halted p=%0d got %0b want %0b", p, bus1.halted, exp_halt);
      else passed++;
    end
    $display("ITERATIONS=1 secret=2: single emission and halt checked");
  endtask

  initial begin
    bus0.stutter_in = 1'b0;
    bus0.secret_in  = 2'd0;
    bus1.stutter_in = 1'b0;
    bus1.secret_in  = 2'd0;
    test_reset();
    test_secret1();
    test_emissions();
    test_stutter();
    test_secret_toggle();
    test_midrun_reset();
    test_iter1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
